// File: rtl/i2c_target_regfile.sv
// I2C target (responder) with a small byte register file.
// Oversamples SCL/SDA in the system clock domain and answers at DEV_ADDR.
// Bus protocol: START, address+R/W, pointer byte, then data bytes.
// The pointer auto-increments with wrap on every written or master-ACKed byte.
// The fabric reads the registers through a registered side port and gets a
// strobe for every byte written from the bus.
// Optional build macro: I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority
// filter on both bus lines, after the synchronizers.
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR = 7'h1A,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned PTR_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    input  logic [PTR_W-1:0] host_addr,
    output logic [7:0]       host_rdata,
    output logic             wr_stb,
    output logic [PTR_W-1:0] wr_addr,
    output logic [7:0]       wr_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWdataAck,
        StRdata,
        StRdMack,
        StWaitStop
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_c;
    logic       sda_c;

    // Two-flop synchronizers; reset to the idle-high bus level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;
    logic       scl_maj;
    logic       sda_maj;

    assign scl_maj = (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1]) |
                     (scl_hist_q[0] & scl_hist_q[1]);
    assign sda_maj = (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1]) |
                     (sda_hist_q[0] & sda_hist_q[1]);

    // Majority of the last three synchronized samples rejects 1-clk pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= scl_maj;
            sda_filt_q <= sda_maj;
        end
    end

    assign scl_c = scl_filt_q;
    assign sda_c = sda_filt_q;
`else
    assign scl_c = scl_sync_q[1];
    assign sda_c = sda_sync_q[1];
`endif

    // ------------------------------------------------------------------
    // Edge and bus-condition detection
    // ------------------------------------------------------------------
    logic scl_prev_q;
    logic sda_prev_q;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    // Previous conditioned sample of each line, for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_c;
            sda_prev_q <= sda_c;
        end
    end

    assign scl_rise  = scl_c & ~scl_prev_q;
    assign scl_fall  = ~scl_c & scl_prev_q;
    // SCL must be high on both samples so an SDA change near an SCL edge is
    // not mistaken for START/STOP.
    assign start_det = scl_c & scl_prev_q & sda_prev_q & ~sda_c;
    assign stop_det  = scl_c & scl_prev_q & ~sda_prev_q & sda_c;

    // ------------------------------------------------------------------
    // Protocol FSM and register file
    // ------------------------------------------------------------------
    state_e           state_q;
    logic [7:0]       shreg_q;
    logic [2:0]       bit_cnt_q;
    logic             byte_full_q;
    logic             rw_q;
    logic             mack_q;
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_inc;
    logic             sda_oe_q;
    logic             busy_q;
    logic             wr_stb_q;
    logic [PTR_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [7:0]       regs_q [NUM_REGS];
    logic             addr_match;
    logic             ptr_ok;

    assign ptr_inc    = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + PTR_W'(1);
    assign addr_match = (shreg_q[7:1] == DEV_ADDR);
    assign ptr_ok     = ({1'b0, shreg_q} < 9'(NUM_REGS));

    // Bytes are shifted in on SCL rise; every decision (ACK drive, release,
    // next read bit) is taken on SCL fall so sda_oe only moves while SCL is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            byte_full_q <= 1'b0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b1;
            ptr_q       <= '0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            wr_stb_q <= 1'b0;
            if (start_det) begin
                state_q     <= StAddr;
                bit_cnt_q   <= 3'd0;
                byte_full_q <= 1'b0;
                sda_oe_q    <= 1'b0;
            end else if (stop_det) begin
                state_q     <= StIdle;
                byte_full_q <= 1'b0;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[6:0], sda_c};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
                        end else if (scl_fall && byte_full_q) begin
                            byte_full_q <= 1'b0;
                            if (addr_match) begin
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                rw_q     <= shreg_q[0];
                                // Preload the read byte; harmless for writes.
                                shreg_q  <= regs_q[ptr_q];
                                state_q  <= StAddrAck;
                            end else begin
                                state_q  <= StWaitStop;
                            end
                        end
                    end
                    StAddrAck: begin
                        if (scl_fall) begin
                            bit_cnt_q <= 3'd0;
                            if (rw_q) begin
                                sda_oe_q <= ~shreg_q[7];
                                state_q  <= StRdata;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= StPtr;
                            end
                        end
                    end
                    StPtr: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[6:0], sda_c};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
                        end else if (scl_fall && byte_full_q) begin
                            byte_full_q <= 1'b0;
                            if (ptr_ok) begin
                                ptr_q    <= shreg_q[PTR_W-1:0];
                                sda_oe_q <= 1'b1;
                                state_q  <= StPtrAck;
                            end else begin
                                // Out-of-range pointer: NACK by leaving SDA released.
                                state_q  <= StWaitStop;
                            end
                        end
                    end
                    StWdata: begin
                        if (scl_rise) begin
                            shreg_q   <= {shreg_q[6:0], sda_c};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) byte_full_q <= 1'b1;
                        end else if (scl_fall && byte_full_q) begin
                            byte_full_q    <= 1'b0;
                            regs_q[ptr_q]  <= shreg_q;
                            wr_stb_q       <= 1'b1;
                            wr_addr_q      <= ptr_q;
                            wr_data_q      <= shreg_q;
                            ptr_q          <= ptr_inc;
                            sda_oe_q       <= 1'b1;
                            state_q        <= StWdataAck;
                        end
                    end
                    StPtrAck, StWdataAck: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= 3'd0;
                            state_q   <= StWdata;
                        end
                    end
                    StRdata: begin
                        if (scl_fall) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                // Release for the master's ACK/NACK clock.
                                sda_oe_q <= 1'b0;
                                state_q  <= StRdMack;
                            end else begin
                                sda_oe_q <= ~shreg_q[6];
                                shreg_q  <= {shreg_q[6:0], 1'b0};
                            end
                        end
                    end
                    StRdMack: begin
                        if (scl_rise) begin
                            mack_q <= sda_c;
                        end else if (scl_fall) begin
                            if (!mack_q) begin
                                ptr_q     <= ptr_inc;
                                shreg_q   <= regs_q[ptr_inc];
                                sda_oe_q  <= ~regs_q[ptr_inc][7];
                                bit_cnt_q <= 3'd0;
                                state_q   <= StRdata;
                            end else begin
                                state_q   <= StWaitStop;
                            end
                        end
                    end
                    default: begin
                        // StIdle / StWaitStop: only START or STOP moves us.
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Fabric read port
    // ------------------------------------------------------------------
    logic [7:0] host_rdata_q;

    // Registered read; a same-cycle bus write returns the old value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            host_rdata_q <= 8'h00;
        end else if (32'(host_addr) < NUM_REGS) begin
            host_rdata_q <= regs_q[host_addr];
        end else begin
            host_rdata_q <= 8'h00;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign host_rdata = host_rdata_q;
    assign wr_stb     = wr_stb_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: a bit-banged I2C master, a transaction-level
// register-file model, a table of directed write transactions, hand-written
// read/reset/glitch sequences and a randomized transaction mix.
module tb_i2c_target_regfile;

    localparam logic [6:0] DEV   = 7'h1A;
    localparam int         NREGS = 16;
    localparam int         Q     = 8;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_m;
    wire        sda_bus;
    logic       sda_oe;
    logic [3:0] host_addr;
    logic [7:0] host_rdata;
    logic       wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    // Open-drain bus: either side can pull low.
    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_regfile #(
        .DEV_ADDR(DEV),
        .NUM_REGS(16),
        .PTR_W   (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .host_addr (host_addr),
        .host_rdata(host_rdata),
        .wr_stb    (wr_stb),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    logic [7:0]  m_regs [NREGS];
    int          m_ptr;
    logic [11:0] exp_q[$];
    logic [11:0] got_q[$];
    logic [7:0]  dbuf [4];
    logic [7:0]  rd_last [4];

    // Observed write strobes
    always @(negedge clk) begin
        if (wr_stb) got_q.push_back({wr_addr, wr_data});
    end

    // sda_oe must never move while SCL is held high (outside reset)
    int   viol = 0;
    logic scl_prev_m = 1'b1;
    logic oe_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset && scl_m && scl_prev_m && (sda_oe !== oe_prev)) viol <= viol + 1;
        scl_prev_m <= scl_m;
        oe_prev    <= sda_oe;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
    endtask

    // ---------------- bus master primitives ----------------
    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(3 * Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic get_bit(output logic b);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        b = sda_bus;  tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    // Sends a byte, optionally with a 1-clk SCL pulse after bit index glitch_after.
    task automatic put_byte(input logic [7:0] v, input int glitch_after, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            put_bit(v[i]);
            if (7 - i == glitch_after) begin
                scl_m = 1'b1; tick(1);
                scl_m = 1'b0; tick(Q);
            end
        end
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(input logic master_ack, output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(~master_ack);
    endtask

    // ---------------- transactions + model ----------------
    task automatic xact_write(input logic [7:0] abyte, input logic [7:0] p, input int n,
                              input bit do_stop, input int glitch,
                              output logic [5:0] acks, output logic [5:0] eacks,
                              output logic bsy);
        logic a;
        acks  = '0;
        eacks = '0;
        bus_start();
        put_byte(abyte, -1, a);
        acks[0]  = a;
        bsy      = busy;
        eacks[0] = (abyte[7:1] == DEV);
        put_byte(p, -1, a);
        acks[1]  = a;
        eacks[1] = eacks[0] && (int'(p) < NREGS);
        if (eacks[1]) m_ptr = int'(p);
        for (int i = 0; i < n; i++) begin
            put_byte(dbuf[i], glitch, a);
            acks[2+i]  = a;
            eacks[2+i] = eacks[1];
            if (eacks[1]) begin
                m_regs[m_ptr] = dbuf[i];
                exp_q.push_back({4'(m_ptr), dbuf[i]});
                m_ptr = (m_ptr + 1) % NREGS;
            end
        end
        if (do_stop) bus_stop();
    endtask

    task automatic xact_read(input logic [7:0] abyte, input int n);
        logic       a;
        logic       match;
        logic [7:0] v;
        match = (abyte[7:1] == DEV);
        bus_start();
        put_byte(abyte, -1, a);
        chk("rd_addr_ack", a, match);
        chk("rd_busy", busy, match);
        for (int i = 0; i < n; i++) begin
            get_byte(i < n - 1, v);
            rd_last[i] = v;
            if (match) begin
                chk("rd_data", v, m_regs[m_ptr]);
                if (i < n - 1) m_ptr = (m_ptr + 1) % NREGS;
            end else begin
                chk("rd_released", v, 8'hFF);
            end
        end
        bus_stop();
        chk("busy_after_stop", busy, 0);
    endtask

    task automatic chk_stb();
        chk("stb_count", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk("stb_entry", got_q.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic chk_host(input int a);
        host_addr = 4'(a);
        tick(2);
        chk("host_rdata", host_rdata, m_regs[a]);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0] abyte;
        logic [7:0] ptr;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [5:0] exp_acks;
        logic       exp_busy;
        int         exp_stb;
        int         chk_reg;
        logic [7:0] chk_val;
    } vec_t;

    vec_t vt [4];

    initial begin
        logic [5:0] acks;
        logic [5:0] eacks;
        logic       bsy;
        logic       a;

        vt[0] = '{8'h34, 8'h02, 8'hA5, 8'h5A, 6'b001111, 1'b1, 2, 3, 8'h5A};
        vt[1] = '{8'h34, 8'h0F, 8'h11, 8'h22, 6'b001111, 1'b1, 2, 0, 8'h22};
        vt[2] = '{8'h36, 8'h03, 8'h77, 8'h88, 6'b000000, 1'b0, 0, 3, 8'h5A};
        vt[3] = '{8'h34, 8'h10, 8'h99, 8'hAA, 6'b000001, 1'b1, 0, 15, 8'h11};

        reset     = 1'b1;
        scl_m     = 1'b1;
        sda_m     = 1'b1;
        host_addr = 4'd0;
        m_reset();
        tick(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_host_rdata", host_rdata, 0);
        reset = 1'b0;
        tick(4);
        chk("host_after_rst", host_rdata, 0);

        for (int k = 0; k < 4; k++) begin
            dbuf[0] = vt[k].d0;
            dbuf[1] = vt[k].d1;
            xact_write(vt[k].abyte, vt[k].ptr, 2, 1'b1, -1, acks, eacks, bsy);
            chk("vec_acks", acks, vt[k].exp_acks);
            chk("vec_busy", bsy, vt[k].exp_busy);
            chk("vec_stb_n", got_q.size(), vt[k].exp_stb);
            chk("vec_busy_stop", busy, 0);
            chk_stb();
            host_addr = 4'(vt[k].chk_reg);
            tick(2);
            chk("vec_host", host_rdata, vt[k].chk_val);
        end
        chk_host(2);

        // Read-back: pointer write, repeated START, read ACK then NACK
        xact_write(8'h34, 8'h02, 0, 1'b0, -1, acks, eacks, bsy);
        chk("rb_ptr_acks", acks, 6'b000011);
        xact_read(8'h35, 2);
        chk("rb_byte0", rd_last[0], 8'hA5);
        chk("rb_byte1", rd_last[1], 8'h5A);

        // Pointer persists across transactions
        xact_write(8'h34, 8'h0F, 0, 1'b1, -1, acks, eacks, bsy);
        xact_read(8'h35, 1);
        chk("persist_byte", rd_last[0], 8'h11);

        // Reset while the target drives SDA during a read
        dbuf[0] = 8'h0F;
        xact_write(8'h34, 8'h05, 1, 1'b1, -1, acks, eacks, bsy);
        chk_stb();
        bus_start();
        put_byte(8'h34, -1, a);
        put_byte(8'h05, -1, a);
        bus_start();
        put_byte(8'h35, -1, a);
        chk("mid_rd_ack", a, 1);
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        chk("oe_before_reset", sda_oe, 1);
        reset = 1'b1;
        #2;
        chk("oe_async_release", sda_oe, 0);
        chk("busy_async_clear", busy, 0);
        tick(3);
        reset = 1'b0;
        m_reset();
        exp_q.delete();
        got_q.delete();
        scl_m = 1'b0;
        tick(Q);
        bus_stop();
        xact_read(8'h35, 2);
        chk_host(5);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // A 1-clk SCL pulse mid-byte must not add a bit
        dbuf[0] = 8'hC3;
        xact_write(8'h34, 8'h07, 1, 1'b1, 3, acks, eacks, bsy);
        chk("glitch_acks", acks, eacks);
        chk_stb();
        chk_host(7);
`endif

        // Randomized transaction mix against the model
        for (int t = 0; t < 16; t++) begin
            int         kind;
            int         n;
            logic [6:0] ad;
            logic [7:0] p;
            kind = $urandom_range(0, 2);
            n    = $urandom_range(1, 3);
            if (kind == 0) begin
                ad = DEV;
                if ($urandom_range(0, 5) == 0) begin
                    ad = 7'($urandom_range(0, 127));
                    if (ad == DEV) ad = ad ^ 7'h01;
                end
                p = 8'($urandom_range(0, 18));
                for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
                xact_write({ad, 1'b0}, p, n, 1'b1, -1, acks, eacks, bsy);
                chk("rnd_wr_acks", acks, eacks);
                chk_stb();
            end else if (kind == 1) begin
                p = 8'($urandom_range(0, 15));
                xact_write({DEV, 1'b0}, p, 0, 1'b0, -1, acks, eacks, bsy);
                chk("rnd_ptr_acks", acks, eacks);
                xact_read({DEV, 1'b1}, n);
            end else begin
                xact_read({DEV, 1'b1}, n);
            end
            chk_host($urandom_range(0, 15));
        end

        chk("oe_stable_scl_high", viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
